// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU uops.
// One uop in flight at a time. A taken branch flushes the uop if it is
// younger than the branch. The result is held in DONE until the result bus
// slot is granted.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, a zero
// divisor or |srcA| < |srcB| goes straight from accept to FIN.
`timescale 1ns/1ps

package div_unit_pkg;
    typedef logic [6:0] Tag;
    typedef logic [4:0] RegNm;
    typedef logic [6:0] SqN;
    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;
endpackage

module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ITER_BITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_valid,
    input  logic [1:0]       IN_opcode,
    input  logic [WIDTH-1:0] IN_srcA,
    input  logic [WIDTH-1:0] IN_srcB,
    input  Tag               IN_tagDst,
    input  RegNm             IN_nmDst,
    input  SqN               IN_sqN,
    input  BranchProv        IN_branch,
    input  logic             IN_wbStall,
    output logic             OUT_busy,
    output logic             OUT_valid,
    output logic [WIDTH-1:0] OUT_result,
    output Tag               OUT_tagDst,
    output RegNm             OUT_nmDst,
    output SqN               OUT_sqN
);

    typedef enum logic [1:0] {IDLE, ITER, FIN, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t               state_reg;
    logic [ITER_BITS-1:0] cnt_reg;
    logic [WIDTH-1:0]     dvd_reg;      // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0]     dvs_reg;      // divisor magnitude
    logic [WIDTH-1:0]     rem_reg;      // partial remainder
    logic [WIDTH-1:0]     quo_reg;      // quotient bits, shifted in LSB side
    logic [WIDTH-1:0]     src_a_reg;    // original dividend, used for the divide-by-zero remainder
    logic                 neg_q_reg;
    logic                 neg_r_reg;
    logic                 is_rem_reg;
    logic                 b_zero_reg;
    logic                 ovf_reg;
    Tag                   tag_reg;
    RegNm                 nm_reg;
    SqN                   sqn_reg;

    // ---------------- operand preparation at accept ----------------
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             b_zero_in;
    logic             ovf_in;
    logic             early;

    assign is_signed = ~IN_opcode[0];
    assign sign_a    = is_signed & IN_srcA[WIDTH-1];
    assign sign_b    = is_signed & IN_srcB[WIDTH-1];
    assign mag_a     = sign_a ? ((~IN_srcA) + ONE) : IN_srcA;
    assign mag_b     = sign_b ? ((~IN_srcB) + ONE) : IN_srcB;
    assign b_zero_in = (IN_srcB == '0);
    assign ovf_in    = is_signed && (IN_srcA == MIN_NEG) && (IN_srcB == '1);

`ifdef DIV_EARLY_OUT_EN
    // Divisor zero or a dividend smaller than the divisor needs no iteration:
    // the quotient is 0 and the remainder is the dividend itself.
    assign early = b_zero_in || (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif

    // ---------------- flush detection (signed sqN difference) ----------------
    SqN   in_diff;
    SqN   held_diff;
    logic in_flush;
    logic held_flush;
    logic accept;

    assign in_diff    = IN_sqN - IN_branch.sqN;
    assign held_diff  = sqn_reg - IN_branch.sqN;
    // A difference that is positive as a signed number marks the uop as younger.
    assign in_flush   = IN_branch.taken && !in_diff[$bits(SqN)-1] && (in_diff != '0);
    assign held_flush = IN_branch.taken && !held_diff[$bits(SqN)-1] && (held_diff != '0);
    assign accept     = (state_reg == IDLE) && IN_valid && !in_flush;

    // ---------------- one restoring step ----------------
    // The shifted remainder can need WIDTH+1 bits when the divisor is above
    // 2^(WIDTH-1), so the compare is done one bit wider.
    logic [WIDTH:0]   rem_shift;
    logic             take;
    logic [WIDTH-1:0] rem_step;

    assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
    assign take      = (rem_shift >= {1'b0, dvs_reg});
    assign rem_step  = take ? (rem_shift[WIDTH-1:0] - dvs_reg) : rem_shift[WIDTH-1:0];

    // ---------------- final sign correction and special cases ----------------
    logic [WIDTH-1:0] fin_quo;
    logic [WIDTH-1:0] fin_rem;
    logic [WIDTH-1:0] fin_result;

    // Apply the signs, then override the divide-by-zero and overflow cases.
    always_comb begin
        fin_quo = neg_q_reg ? ((~quo_reg) + ONE) : quo_reg;
        fin_rem = neg_r_reg ? ((~rem_reg) + ONE) : rem_reg;
        if (b_zero_reg) begin
            fin_quo = '1;
            fin_rem = src_a_reg;
        end else if (ovf_reg) begin
            fin_quo = src_a_reg;
            fin_rem = '0;
        end
        fin_result = is_rem_reg ? fin_rem : fin_quo;
    end

    // The issue queue decides on the registered edge, so a uop on the port
    // already counts as busy in the cycle it is presented.
    assign OUT_busy = (state_reg != IDLE) || IN_valid;

    // Divider state machine with registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            src_a_reg  <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            is_rem_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            tag_reg    <= '0;
            nm_reg     <= '0;
            sqn_reg    <= '0;
            OUT_valid  <= 1'b0;
            OUT_result <= '0;
            OUT_tagDst <= '0;
            OUT_nmDst  <= '0;
            OUT_sqN    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dvd_reg    <= mag_a;
                        dvs_reg    <= mag_b;
                        rem_reg    <= early ? mag_a : '0;
                        quo_reg    <= '0;
                        src_a_reg  <= IN_srcA;
                        neg_q_reg  <= sign_a ^ sign_b;
                        neg_r_reg  <= sign_a;
                        is_rem_reg <= IN_opcode[1];
                        b_zero_reg <= b_zero_in;
                        ovf_reg    <= ovf_in;
                        tag_reg    <= IN_tagDst;
                        nm_reg     <= IN_nmDst;
                        sqn_reg    <= IN_sqN;
                        cnt_reg    <= ITER_BITS'(WIDTH - 1);
                        state_reg  <= early ? FIN : ITER;
                    end
                end
                ITER: begin
                    if (held_flush) begin
                        state_reg <= IDLE;
                    end else begin
                        rem_reg <= rem_step;
                        quo_reg <= {quo_reg[WIDTH-2:0], take};
                        dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
                        cnt_reg <= cnt_reg - ITER_BITS'(1);
                        if (cnt_reg == '0) begin
                            state_reg <= FIN;
                        end
                    end
                end
                FIN: begin
                    if (held_flush) begin
                        state_reg <= IDLE;
                    end else begin
                        OUT_result <= fin_result;
                        OUT_tagDst <= tag_reg;
                        OUT_nmDst  <= nm_reg;
                        OUT_sqN    <= sqn_reg;
                        OUT_valid  <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    // A flush beats a stall; otherwise leave once the slot is granted.
                    if (held_flush || !IN_wbStall) begin
                        OUT_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // A uop offered while the unit is working is ignored and flagged in simulation.
    no_issue_while_busy: assert property (@(posedge clk) disable iff (rst)
        !(IN_valid && (state_reg != IDLE)));

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven checks of div_unit with a scoreboard queue,
// plus hand-written sequences for flush, write-back stall and reset.
`timescale 1ns/1ps

module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [1:0]   in_opcode;
    logic [W-1:0] in_src_a;
    logic [W-1:0] in_src_b;
    Tag           in_tag;
    RegNm         in_nm;
    SqN           in_sqn;
    BranchProv    branch;
    logic         wb_stall;
    logic         out_busy;
    logic         out_valid;
    logic [W-1:0] out_result;
    Tag           out_tag;
    RegNm         out_nm;
    SqN           out_sqn;

    div_unit #(.WIDTH(W), .ITER_BITS(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .IN_valid   (in_valid),
        .IN_opcode  (in_opcode),
        .IN_srcA    (in_src_a),
        .IN_srcB    (in_src_b),
        .IN_tagDst  (in_tag),
        .IN_nmDst   (in_nm),
        .IN_sqN     (in_sqn),
        .IN_branch  (branch),
        .IN_wbStall (wb_stall),
        .OUT_busy   (out_busy),
        .OUT_valid  (out_valid),
        .OUT_result (out_result),
        .OUT_tagDst (out_tag),
        .OUT_nmDst  (out_nm),
        .OUT_sqN    (out_sqn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        Tag           tag;
        RegNm         nm;
        SqN           sqn;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           n_results = 0;
    logic [W-1:0] held_res = '0;
    logic         prev_valid = 1'b0;
    vec_t         vecs[20];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Reference latency: WIDTH+1, or 1 when the early-out build can skip ITER.
    function automatic int lat_of(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic         s;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        s  = ~op[0];
        ma = (s && a[W-1]) ? (W'(0) - a) : a;
        mb = (s && b[W-1]) ? (W'(0) - b) : b;
        if (b == '0 || ma < mb) return 1;
`endif
        return W + 1;
    endfunction

    // Scoreboard monitor: pops at the first cycle of each result, then
    // checks that the held result does not change while valid stays high.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(out_result), 64'hdead);
            end else begin
                e = sb.pop_front();
                $display("result op done: res=%h tag=%0d sqn=%0d lat=%0d", out_result, out_tag, out_sqn, cyc - e.acc);
                check("result", 64'(out_result), 64'(e.res));
                check("tag_nm_sqn", 64'({out_tag, out_nm, out_sqn}), 64'({e.tag, e.nm, e.sqn}));
                check("latency", 64'(cyc - e.acc), 64'(e.lat));
                held_res = e.res;
                n_results++;
            end
        end else if (out_valid) begin
            check("result_hold", 64'(out_result), 64'(held_res));
        end
        prev_valid = out_valid;
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input Tag tag, input RegNm nm, input SqN sqn,
                         input bit expect_out, input logic [W-1:0] exp);
        int k;
        k = 0;
        @(negedge clk);
        while (out_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("busy_timeout", 64'(out_busy), 64'd0);
        in_valid  = 1'b1;
        in_opcode = op;
        in_src_a  = a;
        in_src_b  = b;
        in_tag    = tag;
        in_nm     = nm;
        in_sqn    = sqn;
        if (expect_out) sb.push_back('{exp, tag, nm, sqn, cyc + 1, lat_of(op, a, b)});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int start);
        int k;
        k = 0;
        while (n_results == start && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_results == start) check("result_timeout", 64'(n_results), 64'(start + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int k;

        vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{2'd0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
        vecs[3]  = '{2'd2, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
        vecs[4]  = '{2'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000};
        vecs[5]  = '{2'd2, 32'h80000000,   32'hFFFFFFFF,   32'h00000000};
        vecs[6]  = '{2'd1, 32'd5,          32'd0,          32'hFFFFFFFF};
        vecs[7]  = '{2'd2, 32'd5,          32'd0,          32'd5};
        vecs[8]  = '{2'd0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD};
        vecs[9]  = '{2'd2, 32'd7,          32'hFFFFFFFE,   32'd1};
        vecs[10] = '{2'd1, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1};
        vecs[11] = '{2'd3, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1};
        vecs[12] = '{2'd0, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14};
        vecs[13] = '{2'd2, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE};
        vecs[14] = '{2'd1, 32'd3,          32'd10,         32'd0};
        vecs[15] = '{2'd3, 32'd3,          32'd10,         32'd3};
        vecs[16] = '{2'd0, 32'd5,          32'd0,          32'hFFFFFFFF};
        vecs[17] = '{2'd2, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};
        vecs[18] = '{2'd1, 32'h80000000,   32'd3,          32'h2AAAAAAA};
        vecs[19] = '{2'd3, 32'h80000000,   32'd3,          32'd2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_src_a  = '0;
        in_src_b  = '0;
        in_tag    = '0;
        in_nm     = '0;
        in_sqn    = '0;
        branch    = '{taken: 1'b0, sqN: '0};
        wb_stall  = 1'b0;

        // Reset state, and busy following IN_valid while idle.
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_outs", 64'({out_result, out_tag, out_nm, out_sqn}), 64'd0);
        check("rst_busy_lo", 64'(out_busy), 64'd0);
        in_valid = 1'b1;
        #1;
        check("rst_busy_hi", 64'(out_busy), 64'd1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 20; i++) begin
            start = n_results;
            issue(vecs[i].op, vecs[i].a, vecs[i].b, Tag'(5 + i), RegNm'(i), SqN'(i), 1'b1, vecs[i].exp);
            wait_result(start);
            @(negedge clk);
            #1;
            check("valid_drop", 64'(out_valid), 64'd0);
            check("idle_busy", 64'(out_busy), 64'd0);
        end

        // Younger uop (sqN 10) flushed by a branch with sqN 8 mid-ITER.
        start = n_results;
        issue(2'd1, 32'd100, 32'd7, Tag'(40), RegNm'(3), SqN'(10), 1'b0, '0);
        repeat (11) @(negedge clk);
        branch = '{taken: 1'b1, sqN: SqN'(8)};
        @(negedge clk);
        branch = '{taken: 1'b0, sqN: '0};
        #1;
        check("flush_idle", 64'(out_busy), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_no_result", 64'(n_results), 64'(start));

        // Older branch (sqN 12) leaves the uop alone.
        start = n_results;
        issue(2'd1, 32'd100, 32'd7, Tag'(41), RegNm'(3), SqN'(10), 1'b1, 32'd14);
        repeat (11) @(negedge clk);
        branch = '{taken: 1'b1, sqN: SqN'(12)};
        @(negedge clk);
        branch = '{taken: 1'b0, sqN: '0};
        wait_result(start);

        // Incoming younger uop dropped in the same cycle, across sqN wrap (2 vs 120).
        start = n_results;
        @(negedge clk);
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = 2'd1;
        in_src_a  = 32'd9;
        in_src_b  = 32'd3;
        in_sqn    = SqN'(2);
        branch    = '{taken: 1'b1, sqN: SqN'(120)};
        @(negedge clk);
        in_valid = 1'b0;
        branch   = '{taken: 1'b0, sqN: '0};
        #1;
        check("drop_not_busy", 64'(out_busy), 64'd0);
        repeat (40) @(negedge clk);
        check("drop_no_result", 64'(n_results), 64'(start));

        // Write-back stall for 4 cycles in DONE: valid for 5 samples, then idle.
        start = n_results;
        wb_stall = 1'b1;
        issue(2'd3, 32'd100, 32'd7, Tag'(50), RegNm'(7), SqN'(30), 1'b1, 32'd2);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("stall_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_busy", 64'(out_busy), 64'd1);
            @(negedge clk);
            #1;
        end
        check("stall_last_valid", 64'(out_valid), 64'd1);
        check("stall_last_result", 64'(out_result), 64'd2);
        wb_stall = 1'b0;
        @(negedge clk);
        #1;
        check("stall_release_valid", 64'(out_valid), 64'd0);
        check("stall_release_busy", 64'(out_busy), 64'd0);

        // Asynchronous reset mid-ITER clears every output at once.
        issue(2'd1, 32'd100, 32'd7, Tag'(60), RegNm'(9), SqN'(40), 1'b0, '0);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_outs", 64'({out_result, out_tag, out_nm, out_sqn}), 64'd0);
        check("async_rst_busy", 64'(out_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // New uop after the reset completes normally.
        start = n_results;
        issue(2'd0, 32'hFFFFFFF9, 32'd2, Tag'(61), RegNm'(10), SqN'(41), 1'b1, 32'hFFFFFFFD);
        wait_result(start);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
